axi4_reader: RTL and testbench
==============================

AXI4_READER -- requirements
Module: axi4_reader

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, and the clock and reset ports SHALL be named clk_100Mhz and rst.
REQ-002 The block SHALL have the following parameters (name, default, meaning):
- AXI_ADDR_WIDTH, 32, address width.
- AXI_DATA_WIDTH, 64, data width.
- FRAME_BASE_ADDR, 32'h0100_0000, DDR frame base address.
- BURSTS_PER_FRAME, 300, number of 512-byte bursts per frame.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk_100Mhz, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- frame_start, in, 1, one-cycle pulse that requests a read of a new frame.
- out_prog_full, in, 1, downstream FIFO has fewer than 64 free entries.
- ARADDR, out, 32, read burst address.
- ARVALID, out, 1, read address valid.
- ARREADY, in, 1, read address ready.
- ARLEN, out, 8, constant 63.
- ARSIZE, out, 3, constant 3'b011.
- ARBURST, out, 2, constant 2'b01 (INCR).
- ARCACHE, out, 4, constant 4'b0000.
- ARPROT, out, 3, constant 3'b010.
- RDATA, in, 64, read data.
- RVALID, in, 1, read data valid.
- RREADY, out, 1, read data ready.
- RLAST, in, 1, last beat of the burst.
- RRESP, in, 2, read response.
- out_data, out, 64, data word to the downstream FIFO.
- out_wr_en, out, 1, downstream FIFO write strobe.
- frame_busy, out, 1, a frame read is in progress.
- frame_done, out, 1, one-cycle pulse after the last burst of a frame.
- rd_err, out, 1, sticky read error flag.
- state, out, 2, current FSM state for debug.

Function
REQ-004 The FSM SHALL have four states encoded IDLE=0, ADDR_SEND=1, DATA_RECV=2 and FRAME_END=3, and the state output SHALL reflect the registered state.
REQ-005 In IDLE, when frame_busy=1, out_prog_full=0 and burst_cnt<BURSTS_PER_FRAME, the block SHALL load ARADDR=FRAME_BASE_ADDR+addr_offset and go to ADDR_SEND on the next cycle.
REQ-006 In ADDR_SEND, ARVALID SHALL be 1 and ARADDR SHALL stay stable until the cycle in which ARVALID&&ARREADY is true, then ARVALID SHALL fall and the FSM SHALL go to DATA_RECV.
REQ-007 In DATA_RECV, RREADY SHALL be 1 combinationally from the state, and data SHALL be forwarded with zero latency:
- out_wr_en = RVALID&&RREADY.
- out_data = RDATA.
REQ-008 A 6-bit beat counter SHALL increment on each accepted beat; on the accepted beat with beat_cnt==63, the block SHALL:
- add 512 to addr_offset;
- increment burst_cnt;
- clear beat_cnt;
- return to IDLE.
REQ-009 When burst_cnt reaches BURSTS_PER_FRAME in IDLE, the FSM SHALL enter FRAME_END, pulse frame_done for exactly one cycle, clear frame_busy, and return to IDLE.
REQ-010 A frame_start pulse in IDLE SHALL do the following on the next cycle:
- set frame_busy;
- clear addr_offset and burst_cnt.
REQ-011 A frame_start pulse that arrives during ADDR_SEND, DATA_RECV or FRAME_END SHALL be latched as pending and applied on the next entry to IDLE, and an in-flight burst SHALL never be aborted.
REQ-012 When frame_start and the final beat of a burst coincide, the final beat SHALL complete first and the restart SHALL then be applied in IDLE.
REQ-013 A new burst SHALL be issued only from IDLE with out_prog_full=0, and out_prog_full SHALL be ignored once a burst has started.
REQ-014 addr_offset SHALL be 32 bits and SHALL never exceed (BURSTS_PER_FRAME-1)*512, and ARADDR SHALL never cross a 4 KB boundary within a burst.

Reset
REQ-015 While rst=1 at a clock edge, the block SHALL reset to the following values:
- state=IDLE;
- ARVALID=0;
- ARADDR=FRAME_BASE_ADDR;
- addr_offset=0, burst_cnt=0, beat_cnt=0;
- frame_busy=0, frame_done=0, rd_err=0;
- the pending frame_start flag cleared.
REQ-016 While rst=1, RREADY and out_wr_en SHALL be 0.
REQ-017 A reset asserted mid-burst SHALL abandon the burst, and any beats the interconnect delivers afterwards SHALL not be written to the downstream FIFO.

Configuration
REQ-018 When the macro AXI4_READER_RESP_CHECK_EN is defined, rd_err SHALL be set sticky, until reset, on any of the following:
- an accepted beat with RRESP!=2'b00;
- RLAST=1 with beat_cnt!=63;
- RLAST=0 with beat_cnt==63.
REQ-019 When AXI4_READER_RESP_CHECK_EN is not defined, rd_err SHALL be tied to 0, RRESP and RLAST SHALL be unused, and burst completion SHALL depend only on beat_cnt.

Verification
REQ-020 The bench SHALL cover at least the following directed scenarios:
- Frame start with ARREADY=1, RVALID=1 always and out_prog_full=0 -> 300 bursts with ARADDR 0x0100_0000, 0x0100_0200 … 0x0102_5600, 19200 out_wr_en pulses, one frame_done pulse.
- out_prog_full=1 held for 50 cycles while in IDLE -> no ARVALID; first burst issued within 2 cycles of release.
- ARREADY delayed 7 cycles and RVALID toggled every other cycle -> ARADDR stable while ARVALID=1, exactly 64 writes with out_data equal to RDATA in order.
- frame_start pulsed on beat 30 of burst 5 -> burst 5 completes all 64 beats, next ARADDR=0x0100_0000.
- rst asserted on beat 20 -> ARVALID=0, RREADY=0, state=0 on the next cycle; the next frame_start restarts at the base address.
- With AXI4_READER_RESP_CHECK_EN defined, RRESP=2'b10 on one beat -> rd_err=1 until reset and data still forwarded; without the macro, rd_err stays 0.

Source files
------------

// File: rtl/axi4_reader.sv
// axi4_reader: reads one DDR frame as a sequence of 512-byte INCR bursts and streams the beats into a downstream FIFO.
// Optional macro AXI4_READER_RESP_CHECK_EN enables the sticky rd_err response/RLAST check.
module axi4_reader #(
    parameter int unsigned                AXI_ADDR_WIDTH   = 32,
    parameter int unsigned                AXI_DATA_WIDTH   = 64,
    parameter logic [AXI_ADDR_WIDTH-1:0]  FRAME_BASE_ADDR  = 32'h0100_0000,
    parameter int unsigned                BURSTS_PER_FRAME = 300
) (
    input  logic                      clk_100Mhz,
    input  logic                      rst,
    input  logic                      frame_start,
    input  logic                      out_prog_full,
    output logic [AXI_ADDR_WIDTH-1:0] ARADDR,
    output logic                      ARVALID,
    input  logic                      ARREADY,
    output logic [7:0]                ARLEN,
    output logic [2:0]                ARSIZE,
    output logic [1:0]                ARBURST,
    output logic [3:0]                ARCACHE,
    output logic [2:0]                ARPROT,
    input  logic [AXI_DATA_WIDTH-1:0] RDATA,
    input  logic                      RVALID,
    output logic                      RREADY,
    input  logic                      RLAST,
    input  logic [1:0]                RRESP,
    output logic [AXI_DATA_WIDTH-1:0] out_data,
    output logic                      out_wr_en,
    output logic                      frame_busy,
    output logic                      frame_done,
    output logic                      rd_err,
    output logic [1:0]                state
);

    localparam int unsigned BURST_BYTES = 512;
    localparam int unsigned BURST_CNT_W = $clog2(BURSTS_PER_FRAME + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ADDR_SEND = 2'd1,
        DATA_RECV = 2'd2,
        FRAME_END = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_nx;
    logic [31:0]            addr_offset;
    logic [BURST_CNT_W-1:0] burst_cnt;
    logic [5:0]             beat_cnt;
    logic                   start_pend;
    logic                   start_req;
    logic                   frame_left;
    logic                   beat_acc;
    logic                   last_beat;

    assign ARLEN   = 8'd63;
    assign ARSIZE  = 3'b011;
    assign ARBURST = 2'b01;
    assign ARCACHE = 4'b0000;
    assign ARPROT  = 3'b010;
    assign state   = state_r;

    assign start_req  = frame_start || start_pend;
    assign frame_left = burst_cnt < BURST_CNT_W'(BURSTS_PER_FRAME);
    assign beat_acc   = RVALID && RREADY;
    assign last_beat  = beat_acc && (beat_cnt == 6'd63);

    // State register
    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next state: a pending restart always wins over issuing another burst
    always_comb begin
        state_nx = state_r;
        case (state_r)
            IDLE: begin
                if (!start_req && frame_busy) begin
                    if (!frame_left) begin
                        state_nx = FRAME_END;
                    end else if (!out_prog_full) begin
                        state_nx = ADDR_SEND;
                    end
                end
            end
            ADDR_SEND: if (ARREADY) state_nx = DATA_RECV;
            DATA_RECV: if (last_beat) state_nx = IDLE;
            FRAME_END: state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // Handshake outputs decode the registered state and are forced low in reset
    always_comb begin
        ARVALID = 1'b0;
        RREADY  = 1'b0;
        if (!rst) begin
            ARVALID = (state_r == ADDR_SEND);
            RREADY  = (state_r == DATA_RECV);
        end
    end

    assign out_wr_en = beat_acc;
    assign out_data  = RDATA;

    // Frame bookkeeping and burst address generation
    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            ARADDR      <= FRAME_BASE_ADDR;
            addr_offset <= '0;
            burst_cnt   <= '0;
            beat_cnt    <= '0;
            frame_busy  <= 1'b0;
            frame_done  <= 1'b0;
            start_pend  <= 1'b0;
        end else begin
            frame_done <= (state_r == IDLE) && (state_nx == FRAME_END);
            case (state_r)
                IDLE: begin
                    if (start_req) begin
                        frame_busy  <= 1'b1;
                        addr_offset <= '0;
                        burst_cnt   <= '0;
                        start_pend  <= 1'b0;
                    end else if (state_nx == ADDR_SEND) begin
                        ARADDR <= FRAME_BASE_ADDR + AXI_ADDR_WIDTH'(addr_offset);
                    end
                end
                DATA_RECV: begin
                    if (beat_acc) begin
                        beat_cnt <= last_beat ? 6'd0 : beat_cnt + 6'd1;
                    end
                    if (last_beat) begin
                        burst_cnt <= burst_cnt + BURST_CNT_W'(1);
                        // offset parks on the last burst so it never points past the frame
                        if (burst_cnt != BURST_CNT_W'(BURSTS_PER_FRAME - 1)) begin
                            addr_offset <= addr_offset + 32'(BURST_BYTES);
                        end
                    end
                end
                FRAME_END: frame_busy <= 1'b0;
                default: ;
            endcase
            if (frame_start && (state_r != IDLE)) begin
                start_pend <= 1'b1;
            end
        end
    end

`ifdef AXI4_READER_RESP_CHECK_EN
    // Sticky error on bad response or RLAST out of step with the beat count
    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            rd_err <= 1'b0;
        end else if (beat_acc && ((RRESP != 2'b00) || (RLAST != (beat_cnt == 6'd63)))) begin
            rd_err <= 1'b1;
        end
    end
`else
    logic unused_resp;
    assign unused_resp = ^{RRESP, RLAST};
    assign rd_err      = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_reader.sv
// Directed bench for axi4_reader: an AXI read-slave model feeds beats, a scoreboard
// monitor checks burst addresses and forwarded data against queued expectations.
module tb_axi4_reader;

    localparam logic [31:0] BASE = 32'h0100_0000;

    logic        clk_100Mhz = 1'b0;
    logic        rst;
    logic        frame_start;
    logic        out_prog_full;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic [3:0]  ARCACHE;
    logic [2:0]  ARPROT;
    logic [63:0] RDATA;
    logic        RVALID;
    logic        RREADY;
    logic        RLAST;
    logic [1:0]  RRESP;
    logic [63:0] out_data;
    logic        out_wr_en;
    logic        frame_busy;
    logic        frame_done;
    logic        rd_err;
    logic [1:0]  state;

    axi4_reader dut (
        .clk_100Mhz   (clk_100Mhz),
        .rst          (rst),
        .frame_start  (frame_start),
        .out_prog_full(out_prog_full),
        .ARADDR       (ARADDR),
        .ARVALID      (ARVALID),
        .ARREADY      (ARREADY),
        .ARLEN        (ARLEN),
        .ARSIZE       (ARSIZE),
        .ARBURST      (ARBURST),
        .ARCACHE      (ARCACHE),
        .ARPROT       (ARPROT),
        .RDATA        (RDATA),
        .RVALID       (RVALID),
        .RREADY       (RREADY),
        .RLAST        (RLAST),
        .RRESP        (RRESP),
        .out_data     (out_data),
        .out_wr_en    (out_wr_en),
        .frame_busy   (frame_busy),
        .frame_done   (frame_done),
        .rd_err       (rd_err),
        .state        (state)
    );

    always #5 clk_100Mhz = ~clk_100Mhz;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_addr[$];
    logic [63:0] exp_data[$];
    int wr_cnt = 0, hs_cnt = 0, done_cnt = 0, arv_cnt = 0;

    // slave model controls
    int ar_delay = 0, ar_wait = 0, beats_left = 0, seq = 0, err_seq = -1;
    bit toggle = 0, orphan = 0, abort = 0;
    bit s_acc, s_hs, s_arv;

    int w0, a0, h0, d0, w_rst;

`ifdef AXI4_READER_RESP_CHECK_EN
    localparam logic RD_ERR_EXP = 1'b1;
`else
    localparam logic RD_ERR_EXP = 1'b0;
`endif

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [63:0] pat(input int s);
        return {16'hC0DE, s[15:0], ~s};
    endfunction

    function automatic int get_cnt(input int which);
        case (which)
            0:       return wr_cnt;
            1:       return hs_cnt;
            2:       return done_cnt;
            default: return arv_cnt;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk_100Mhz);
        #2;
    endtask

    task automatic pulse_start();
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // which: 0 writes, 1 AR handshakes, 2 frame_done pulses, 3 ARVALID cycles
    task automatic wait_cnt(input int which, input int target, input int budget, input string name);
        int n;
        n = 0;
        while (get_cnt(which) < target && n < budget) begin
            @(negedge clk_100Mhz);
            #1;
            n++;
        end
        check(name, 64'(get_cnt(which) >= target), 64'd1);
    endtask

    // AXI read slave: ARREADY after ar_delay ARVALID cycles, 64 beats per accepted address
    initial begin
        ARREADY = 1'b1;
        RVALID  = 1'b0;
        RDATA   = '0;
        RLAST   = 1'b0;
        RRESP   = 2'b00;
        forever begin
            @(negedge clk_100Mhz);
            s_acc = RVALID && RREADY;
            s_hs  = ARVALID && ARREADY;
            s_arv = ARVALID;
            @(posedge clk_100Mhz);
            #1;
            if (ar_delay == 0) begin
                ARREADY = 1'b1;
            end else if (s_hs) begin
                ARREADY = 1'b0;
                ar_wait = 0;
            end else if (s_arv) begin
                ar_wait++;
                if (ar_wait >= ar_delay) ARREADY = 1'b1;
            end else begin
                ARREADY = 1'b0;
                ar_wait = 0;
            end
            if (abort) begin
                beats_left = 0;
                RVALID     = 1'b0;
                RLAST      = 1'b0;
            end else begin
                if (s_hs) beats_left = 64;
                if (s_acc) begin
                    beats_left--;
                    seq++;
                end
                if (beats_left == 0) begin
                    RVALID = 1'b0;
                    RLAST  = 1'b0;
                end else if (!RVALID || s_acc) begin
                    if (toggle && s_acc) begin
                        RVALID = 1'b0;
                    end else begin
                        RVALID = 1'b1;
                        RDATA  = pat(seq);
                        RLAST  = (beats_left == 1);
                        RRESP  = (seq == err_seq) ? 2'b10 : 2'b00;
                        if (!orphan) exp_data.push_back(pat(seq));
                    end
                end
            end
        end
    end

    // Scoreboard monitor
    initial begin
        logic        prev_arv = 1'b0, prev_hs = 1'b0, prev_done = 1'b0;
        logic [31:0] prev_addr = '0;
        forever begin
            @(negedge clk_100Mhz);
            if (ARVALID) arv_cnt++;
            if (ARVALID && prev_arv && !prev_hs) check("araddr_stable", ARADDR, prev_addr);
            if (ARVALID && ARREADY) begin
                hs_cnt++;
                if (exp_addr.size() == 0) check("araddr_unexpected_burst", 64'(ARADDR), 64'hFFFF_FFFF_FFFF_FFFF);
                else check("araddr", ARADDR, exp_addr.pop_front());
            end
            if (out_wr_en) begin
                wr_cnt++;
                if (exp_data.size() == 0) check("out_data_unexpected_write", out_data, 64'hFFFF_FFFF_FFFF_FFFF);
                else check("out_data", out_data, exp_data.pop_front());
            end
            if (frame_done) begin
                done_cnt++;
                check("frame_done_width", 64'(prev_done), 64'd0);
            end
            prev_arv  = ARVALID;
            prev_hs   = ARVALID && ARREADY;
            prev_addr = ARADDR;
            prev_done = frame_done;
        end
    end

    initial begin
        #600000;
        n_errors++;
        $display("FAIL watchdog: run did not complete, got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        frame_start   = 1'b0;
        out_prog_full = 1'b0;
        repeat (3) @(posedge clk_100Mhz);
        @(negedge clk_100Mhz);
        check("rst_state", 64'(state), 64'd0);
        check("rst_arvalid", 64'(ARVALID), 64'd0);
        check("rst_rready", 64'(RREADY), 64'd0);
        check("rst_wr_en", 64'(out_wr_en), 64'd0);
        check("rst_araddr", 64'(ARADDR), 64'(BASE));
        check("rst_busy", 64'(frame_busy), 64'd0);
        check("rst_done", 64'(frame_done), 64'd0);
        check("rst_rd_err", 64'(rd_err), 64'd0);
        tick();
        rst = 1'b0;

        // Full frame at full throughput
        for (int i = 0; i < 300; i++) exp_addr.push_back(BASE + 32'(i * 512));
        w0 = wr_cnt;
        d0 = done_cnt;
        pulse_start();
        check("t1_busy", 64'(frame_busy), 64'd1);
        wait_cnt(2, d0 + 1, 25000, "t1_frame_done_seen");
        repeat (3) tick();
        check("t1_writes", 64'(wr_cnt - w0), 64'd19200);
        check("t1_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("t1_busy_cleared", 64'(frame_busy), 64'd0);
        check("t1_addr_left", 64'(exp_addr.size()), 64'd0);

        // Backpressure while idle, one burst after release
        out_prog_full = 1'b1;
        a0 = arv_cnt;
        pulse_start();
        repeat (50) tick();
        check("t2_no_arvalid", 64'(arv_cnt - a0), 64'd0);
        exp_addr.push_back(BASE);
        w0 = wr_cnt;
        a0 = arv_cnt;
        out_prog_full = 1'b0;
        wait_cnt(3, a0 + 1, 2, "t2_issue_latency");
        out_prog_full = 1'b1;
        wait_cnt(0, w0 + 64, 200, "t2_burst_done");
        a0 = arv_cnt;
        repeat (10) tick();
        check("t2_writes", 64'(wr_cnt - w0), 64'd64);
        check("t2_stalled", 64'(arv_cnt - a0), 64'd0);

        // Slow ARREADY, gappy RVALID, one error response
        ar_delay = 7;
        toggle   = 1'b1;
        err_seq  = seq + 10;
        pulse_start();
        exp_addr.push_back(BASE);
        w0 = wr_cnt;
        a0 = arv_cnt;
        out_prog_full = 1'b0;
        wait_cnt(3, a0 + 1, 3, "t3_arvalid");
        out_prog_full = 1'b1;
        wait_cnt(0, w0 + 64, 400, "t3_burst_done");
        repeat (10) tick();
        check("t3_writes", 64'(wr_cnt - w0), 64'd64);
        check("t3_arvalid_cycles", 64'(arv_cnt - a0), 64'd8);
        check("t3_rd_err", 64'(rd_err), 64'(RD_ERR_EXP));
        ar_delay = 0;
        toggle   = 1'b0;
        err_seq  = -1;

        // Restart requested mid-burst 5
        for (int i = 0; i < 6; i++) exp_addr.push_back(BASE + 32'(i * 512));
        exp_addr.push_back(BASE);
        pulse_start();
        w0 = wr_cnt;
        h0 = hs_cnt;
        out_prog_full = 1'b0;
        wait_cnt(0, w0 + 5 * 64 + 30, 2000, "t4_reach_beat30");
        pulse_start();
        wait_cnt(1, h0 + 7, 2000, "t4_restart_burst");
        out_prog_full = 1'b1;
        wait_cnt(0, w0 + 7 * 64, 1000, "t4_bursts_done");
        repeat (10) tick();
        check("t4_writes", 64'(wr_cnt - w0), 64'd448);
        check("t4_bursts", 64'(hs_cnt - h0), 64'd7);
        check("t4_addr_left", 64'(exp_addr.size()), 64'd0);

        // Reset on beat 20, then restart from base
        exp_addr.push_back(BASE);
        pulse_start();
        w0 = wr_cnt;
        a0 = arv_cnt;
        out_prog_full = 1'b0;
        wait_cnt(3, a0 + 1, 3, "t5_arvalid");
        out_prog_full = 1'b1;
        wait_cnt(0, w0 + 20, 200, "t5_beat20");
        tick();
        rst    = 1'b1;
        orphan = 1'b1;
        w_rst  = wr_cnt;
        @(negedge clk_100Mhz);
        check("t5_rready_in_rst", 64'(RREADY), 64'd0);
        check("t5_wr_en_in_rst", 64'(out_wr_en), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk_100Mhz);
        check("t5_state_after_rst", 64'(state), 64'd0);
        check("t5_arvalid_after_rst", 64'(ARVALID), 64'd0);
        check("t5_rready_after_rst", 64'(RREADY), 64'd0);
        check("t5_busy_after_rst", 64'(frame_busy), 64'd0);
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort  = 1'b0;
        orphan = 1'b0;
        exp_data.delete();
        check("t5_no_orphan_writes", 64'(wr_cnt - w_rst), 64'd0);
        check("t5_rd_err_cleared", 64'(rd_err), 64'd0);
        exp_addr.push_back(BASE);
        pulse_start();
        w0 = wr_cnt;
        a0 = arv_cnt;
        out_prog_full = 1'b0;
        wait_cnt(3, a0 + 1, 3, "t5_restart_arvalid");
        check("t5_restart_araddr", 64'(ARADDR), 64'(BASE));
        out_prog_full = 1'b1;
        wait_cnt(0, w0 + 64, 200, "t5_restart_burst");
        repeat (5) tick();
        check("t5_restart_writes", 64'(wr_cnt - w0), 64'd64);
        check("end_data_left", 64'(exp_data.size()), 64'd0);
        check("end_addr_left", 64'(exp_addr.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
